// File: rtl/apb_cfg_master.sv
//==============================================================================
// Module   : apb_cfg_master
// Brief    : Single-outstanding APB initiator for the vending-machine config
//            bus. Define APB_MST_TIMEOUT_EN to enable the ACCESS-phase timeout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_cfg_master #(
   parameter int ADDR_W         = 15,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              pclk,
   input  logic              prstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_TURN   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                w_cmd_hs;
   logic                w_rsp_hs;

   // Out-of-range TIMEOUT_CYCLES leaves this marker in the elaborated tree.
   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range_illegal
   end

`ifdef APB_MST_TIMEOUT_EN
   localparam logic [15:0] c_tmo_match = 16'(TIMEOUT_CYCLES - 1);

   logic                rsp_err_q, rsp_err_d;
   logic [15:0]         tmo_cnt_q, tmo_cnt_d;
`endif

   // A slave still holding pready from the previous transfer blocks new work.
   assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q && !pready;
   assign w_cmd_hs  = cmd_valid && cmd_ready;
   assign w_rsp_hs  = rsp_valid_q && rsp_ready;
   assign busy      = (state_q != ST_IDLE) || rsp_valid_q;

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MST_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state_q     <= ST_IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef APB_MST_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MST_TIMEOUT_EN
         rsp_err_q   <= rsp_err_d;
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MST_TIMEOUT_EN
      rsp_err_d   = rsp_err_q;
      tmo_cnt_d   = tmo_cnt_q;
`endif

      if (w_rsp_hs) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (w_cmd_hs) begin
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
`ifdef APB_MST_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            // pready is checked first so a completion on the limit cycle is not an error.
            if (pready) begin
               rsp_rdata_d = pwrite_q ? '0 : prdata;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
               state_d     = ST_TURN;
            end
`ifdef APB_MST_TIMEOUT_EN
            else if (tmo_cnt_q == c_tmo_match) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = ST_TURN;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
`endif
         end
         ST_TURN: begin
            if (!pready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_apb_cfg_master.sv
//==============================================================================
// Module   : tb_apb_cfg_master
// Brief    : Self-checking bench for apb_cfg_master with an APB slave model and
//            a transfer-level reference. Honours APB_MST_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_apb_cfg_master;
   localparam int AW  = 15;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          pclk = 1'b0;
   logic          prstn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_err, busy;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite, pready;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 pclk = ~pclk;

   apb_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .pclk(pclk), .prstn(prstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // APB slave: answers slv_lat cycles after seeing psel, keeps pready for slv_hold more.
   int            slv_lat  = 1;
   int            slv_hold = 0;
   bit            slv_hang = 1'b0;
   int            slv_cnt, hold_cnt;
   logic [DW-1:0] slv_mem [16] = '{default: '0};

   always @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         pready   <= 1'b0;
         prdata   <= '0;
         slv_cnt  <= 0;
         hold_cnt <= 0;
      end else if (pready) begin
         if (psel && penable && pwrite) slv_mem[paddr[5:2]] <= pwdata;
         if (hold_cnt == 0) pready <= 1'b0;
         else hold_cnt <= hold_cnt - 1;
      end else if (psel && !slv_hang) begin
         if (slv_cnt >= slv_lat) begin
            pready   <= 1'b1;
            prdata   <= slv_mem[paddr[5:2]];
            slv_cnt  <= 0;
            hold_cnt <= slv_hold;
         end else begin
            slv_cnt <= slv_cnt + 1;
         end
      end else begin
         slv_cnt <= 0;
      end
   end

   // Bus and response activity counters.
   int            xfer_cnt = 0;
   int            rsp_cnt  = 0;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_wdata;
   logic          last_write;

   always @(posedge pclk) begin
      cyc <= cyc + 1;
      if (prstn && psel && penable && pready) begin
         xfer_cnt   <= xfer_cnt + 1;
         last_addr  <= paddr;
         last_wdata <= pwdata;
         last_write <= pwrite;
      end
      if (prstn && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
   end

   // Transfer-level reference: one in-flight transfer, aged in cycles since acceptance.
   logic          m_active, m_turn, m_rsp_pend, m_rsp_err, m_write;
   int            m_age;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rsp_data;
   logic [DW-1:0] shadow [16] = '{default: '0};
   logic          exp_cmd_ready, exp_busy, exp_penable;

   assign exp_cmd_ready = !m_active && !m_turn && !m_rsp_pend && !pready;
   assign exp_busy      = m_active || m_turn || m_rsp_pend;
   assign exp_penable   = m_active && (m_age >= 1);

   always @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         m_active <= 1'b0; m_turn <= 1'b0; m_rsp_pend <= 1'b0; m_rsp_err <= 1'b0;
         m_write <= 1'b0; m_age <= 0; m_addr <= '0; m_wdata <= '0; m_rsp_data <= '0;
      end else begin
         if (m_rsp_pend && rsp_ready) m_rsp_pend <= 1'b0;
         if (m_turn && !pready) m_turn <= 1'b0;
         if (m_active) begin
            m_age <= m_age + 1;
            if (m_age >= 1 && pready) begin
               m_active   <= 1'b0;
               m_turn     <= 1'b1;
               m_rsp_pend <= 1'b1;
               m_rsp_err  <= 1'b0;
               m_rsp_data <= m_write ? '0 : shadow[m_addr[5:2]];
               if (m_write) shadow[m_addr[5:2]] <= m_wdata;
            end
`ifdef APB_MST_TIMEOUT_EN
            else if (m_age == TMO) begin
               m_active   <= 1'b0;
               m_turn     <= 1'b1;
               m_rsp_pend <= 1'b1;
               m_rsp_err  <= 1'b1;
               m_rsp_data <= '0;
            end
`endif
         end else if (cmd_valid && exp_cmd_ready) begin
            m_active <= 1'b1;
            m_age    <= 0;
            m_write  <= cmd_write;
            m_addr   <= cmd_addr;
            m_wdata  <= cmd_wdata;
         end
      end
   end

   always @(negedge pclk) begin
      check("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
      check("busy",      32'(busy),      32'(exp_busy));
      check("psel",      32'(psel),      32'(m_active));
      check("penable",   32'(penable),   32'(exp_penable));
      check("pwrite",    32'(pwrite),    32'(m_write));
      check("paddr",     32'(paddr),     32'(m_addr));
      check("pwdata",    pwdata,         m_wdata);
      check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_pend));
      check("rsp_rdata", rsp_rdata,      m_rsp_data);
      check("rsp_err",   32'(rsp_err),   32'(m_rsp_err));
   end

   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit keep, output int hs_edge);
      bit got = 1'b0;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge pclk);
         if (cmd_ready) begin got = 1'b1; break; end
      end
      check("cmd_accepted", 32'(got), 32'd1);
      hs_edge = cyc + 1;
      @(posedge pclk); #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int limit, output logic [DW-1:0] d, output logic e,
                           output int at_cyc, output bit got);
      got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge pclk);
         if (rsp_valid) begin got = 1'b1; break; end
      end
      d = rsp_rdata; e = rsp_err; at_cyc = cyc;
   endtask

   initial begin
      int hs, hs2, at, n0, x0;
      logic [DW-1:0] d;
      logic e;
      bit got;

      prstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge pclk);
      #1;
      check("rst_psel", 32'(psel), 32'd0);
      check("rst_penable", 32'(penable), 32'd0);
      check("rst_paddr", 32'(paddr), 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      prstn = 1'b1;
      @(posedge pclk); #1;

      // Write 5 to the item-count register, then read it back.
      send(1'b1, 15'h0000, 32'h0000_0005, 1'b0, hs);
      wait_rsp(20, d, e, at, got);
      check("wr0_rsp", 32'(got), 32'd1);
      check("wr0_err", 32'(e), 32'd0);
      check("wr0_latency", 32'(at - hs), 32'd3);
      @(posedge pclk); #1;
      check("wr0_bus_addr", 32'(last_addr), 32'h0);
      check("wr0_bus_wdata", last_wdata, 32'h5);
      check("wr0_bus_write", 32'(last_write), 32'd1);
      send(1'b0, 15'h0000, 32'h0, 1'b0, hs);
      wait_rsp(20, d, e, at, got);
      check("rd0_data", d, 32'h0000_0005);
      @(posedge pclk); #1;

      // Item memory write, then a read with a slow slave.
      send(1'b1, 15'h0008, 32'hA5A5_1234, 1'b0, hs);
      wait_rsp(20, d, e, at, got);
      @(posedge pclk); #1;
      slv_lat = 4;
      n0 = rsp_cnt;
      send(1'b0, 15'h0008, 32'h0, 1'b0, hs);
      wait_rsp(30, d, e, at, got);
      check("rd8_data", d, 32'hA5A5_1234);
      check("rd8_latency", 32'(at - hs), 32'd6);
      repeat (5) @(posedge pclk);
      #1;
      check("rd8_one_rsp", 32'(rsp_cnt - n0), 32'd1);

      // Back-to-back writes with cmd_valid held and pready lingering after completion.
      slv_lat = 1; slv_hold = 2;
      x0 = xfer_cnt; n0 = rsp_cnt;
      send(1'b1, 15'h000C, 32'h1111_0001, 1'b1, hs);
      send(1'b1, 15'h0010, 32'h2222_0002, 1'b0, hs2);
      repeat (15) @(posedge pclk);
      #1;
      check("b2b_gap", 32'(hs2 - hs), 32'd7);
      check("b2b_xfers", 32'(xfer_cnt - x0), 32'd2);
      check("b2b_rsps", 32'(rsp_cnt - n0), 32'd2);
      slv_hold = 0;
      send(1'b0, 15'h000C, 32'h0, 1'b0, hs);
      wait_rsp(20, d, e, at, got);
      check("rdC_data", d, 32'h1111_0001);
      @(posedge pclk); #1;
      send(1'b0, 15'h0010, 32'h0, 1'b0, hs);
      wait_rsp(20, d, e, at, got);
      check("rd10_data", d, 32'h2222_0002);
      @(posedge pclk); #1;

      // Host stalls the response for 10 cycles.
      rsp_ready = 1'b0;
      send(1'b0, 15'h0008, 32'h0, 1'b0, hs);
      wait_rsp(20, d, e, at, got);
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_rdata", rsp_rdata, 32'hA5A5_1234);
         check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge pclk);
      check("stall_release_valid", 32'(rsp_valid), 32'd0);
      check("stall_release_ready", 32'(cmd_ready), 32'd1);
      @(posedge pclk); #1;

      // Asynchronous reset while stuck in ACCESS.
      slv_hang = 1'b1;
      send(1'b0, 15'h0004, 32'h0, 1'b0, hs);
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         if (penable) break;
      end
      @(posedge pclk); #2;
      prstn = 1'b0;
      #1;
      check("arst_psel", 32'(psel), 32'd0);
      check("arst_penable", 32'(penable), 32'd0);
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge pclk);
      prstn = 1'b1; slv_hang = 1'b0;
      @(posedge pclk); #1;
      send(1'b0, 15'h0000, 32'h0, 1'b0, hs);
      wait_rsp(20, d, e, at, got);
      check("post_rst_rsp", 32'(got), 32'd1);
      check("post_rst_data", d, 32'h0000_0005);
      @(posedge pclk); #1;

      // Slave never answers.
      slv_hang = 1'b1;
      send(1'b0, 15'h0004, 32'h0, 1'b0, hs);
`ifdef APB_MST_TIMEOUT_EN
      wait_rsp(40, d, e, at, got);
      check("tmo_rsp", 32'(got), 32'd1);
      check("tmo_err", 32'(e), 32'd1);
      check("tmo_data", d, 32'h0);
      check("tmo_latency", 32'(at - hs), 32'd9);
      check("tmo_psel", 32'(psel), 32'd0);
      @(posedge pclk); #1;
`else
      wait_rsp(100, d, e, at, got);
      check("hang_no_rsp", 32'(got), 32'd0);
      check("hang_psel", 32'(psel), 32'd1);
      prstn = 1'b0;
      @(negedge pclk);
      prstn = 1'b1;
`endif
      slv_hang = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: run still active, expected finish before 200000");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
